// File: rtl/apb_timer_scheduler_if.sv
// APB bundle between the timer scheduler (master) and the APB_TIMER slave port.
interface apb_timer_scheduler_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [9:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_timer_scheduler.sv
// Shares one APB_TIMER between NUM_REQ one-shot delay clients. A round-robin
// arbiter picks a client, the FSM programs RELOAD/VALUE/CTRL, waits for the
// interrupt, clears it, disables the timer and pulses done/err to the owner.
module apb_timer_scheduler #(
   parameter int NUM_REQ = 4
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_delay,
   output logic [NUM_REQ-1:0]    done,
   output logic [NUM_REQ-1:0]    err,
   output logic                  busy,
   apb_timer_scheduler_if.master apb,
   input  logic                  timerint
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Timer register word addresses (byte offset >> 2)
   localparam logic [9:0] ADDR_CTRL   = 10'h000;
   localparam logic [9:0] ADDR_VALUE  = 10'h001;
   localparam logic [9:0] ADDR_RELOAD = 10'h002;
   localparam logic [9:0] ADDR_INTCLR = 10'h003;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_WAIT_IRQ,
      S_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [2:0]       step_reg, step_next;
   logic [IDX_W-1:0] owner_reg, owner_next;
   logic [IDX_W-1:0] rr_last_reg, rr_last_next;
   logic [31:0]      delay_reg, delay_next;
   logic             err_flag_reg, err_flag_next;

   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] cand_idx;
   logic [31:0]      grant_delay;
   logic [31:0]      delay_arr [NUM_REQ];

   // Read data is never needed: every transfer is a write
   logic unused_prdata;
   assign unused_prdata = ^apb.prdata;

   // Split the flat delay bus and build per-client completion pulses
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_client
      assign delay_arr[gi] = req_delay[gi*32 +: 32];
      assign done[gi] = (state_reg == S_DONE) && (owner_reg == IDX_W'(gi));
      assign err[gi]  = (state_reg == S_DONE) && (owner_reg == IDX_W'(gi)) && err_flag_reg;
   end

   // Round-robin search starting just after the last owner; iterating from the
   // far end lets the nearest active client overwrite earlier candidates
   always_comb begin
      grant_valid = |req;
      grant_idx   = '0;
      cand_idx    = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand_idx = IDX_W'((int'(rr_last_reg) + i) % NUM_REQ);
         if (req[cand_idx]) begin
            grant_idx = cand_idx;
         end
      end
      grant_delay = delay_arr[grant_idx];
   end

   // APB control decoded straight from state so reset drops psel/penable at once
   assign apb.psel    = (state_reg == S_SETUP) || (state_reg == S_ACCESS);
   assign apb.penable = (state_reg == S_ACCESS);
   assign apb.pwrite  = (state_reg == S_SETUP) || (state_reg == S_ACCESS);
   assign busy        = (state_reg != S_IDLE);

   // Address/data per step; held identical through SETUP and ACCESS
   always_comb begin
      apb.paddr  = '0;
      apb.pwdata = '0;
      if ((state_reg == S_SETUP) || (state_reg == S_ACCESS)) begin
         case (step_reg)
            3'd0: begin apb.paddr = ADDR_RELOAD; apb.pwdata = 32'h0;     end
            3'd1: begin apb.paddr = ADDR_VALUE;  apb.pwdata = delay_reg; end
            3'd2: begin apb.paddr = ADDR_CTRL;   apb.pwdata = 32'h9;     end
            3'd3: begin apb.paddr = ADDR_INTCLR; apb.pwdata = 32'h1;     end
            default: begin apb.paddr = ADDR_CTRL; apb.pwdata = 32'h0;    end
         endcase
      end
   end

   // Next-state logic: arbitration, transfer sequencing and error redirect
   always_comb begin
      state_next    = state_reg;
      step_next     = step_reg;
      owner_next    = owner_reg;
      rr_last_next  = rr_last_reg;
      delay_next    = delay_reg;
      err_flag_next = err_flag_reg;
      case (state_reg)
         S_IDLE: begin
            if (grant_valid) begin
               owner_next   = grant_idx;
               rr_last_next = grant_idx;
               delay_next   = grant_delay;
               step_next    = 3'd0;
               // A zero load never interrupts, so skip the timer entirely
               if (grant_delay == 32'd0) begin
                  err_flag_next = 1'b1;
                  state_next    = S_DONE;
               end else begin
                  err_flag_next = 1'b0;
                  state_next    = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            state_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (apb.pready) begin
               if (apb.pslverr) begin
                  err_flag_next = 1'b1;
               end
               case (step_reg)
                  3'd0, 3'd1, 3'd2: begin
                     if (apb.pslverr) begin
                        // Programming failed: go straight to cleanup
                        step_next  = 3'd3;
                        state_next = S_SETUP;
                     end else if (step_reg == 3'd2) begin
                        state_next = S_WAIT_IRQ;
                     end else begin
                        step_next  = step_reg + 3'd1;
                        state_next = S_SETUP;
                     end
                  end
                  3'd3: begin
                     step_next  = 3'd4;
                     state_next = S_SETUP;
                  end
                  default: begin
                     state_next = S_DONE;
                  end
               endcase
            end
         end
         S_WAIT_IRQ: begin
            if (timerint) begin
               step_next  = 3'd3;
               state_next = S_SETUP;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State registers; rr_last resets to the top index so client 0 goes first
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_reg    <= S_IDLE;
         step_reg     <= 3'd0;
         owner_reg    <= '0;
         rr_last_reg  <= IDX_W'(NUM_REQ - 1);
         delay_reg    <= 32'd0;
         err_flag_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         step_reg     <= step_next;
         owner_reg    <= owner_next;
         rr_last_reg  <= rr_last_next;
         delay_reg    <= delay_next;
         err_flag_reg <= err_flag_next;
      end
   end

endmodule

// File: tb/tb_apb_timer_scheduler.sv
// Scoreboard bench for apb_timer_scheduler: stimulus pushes expected APB writes
// and done/err vectors; a monitor pops and compares as the DUT produces them.
module tb_apb_timer_scheduler;

   localparam int N     = 4;
   localparam int LIMIT = 3000;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } apb_wr_t;

   logic           pclk = 1'b0;
   logic           presetn;
   logic [N-1:0]   req;
   logic [N*32-1:0] req_delay;
   logic [N-1:0]   done;
   logic [N-1:0]   err;
   logic           busy;
   logic           timerint;

   apb_timer_scheduler_if apb();

   apb_timer_scheduler #(.NUM_REQ(N)) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .req       (req),
      .req_delay (req_delay),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .apb       (apb),
      .timerint  (timerint)
   );

   always #5 pclk = ~pclk;

   int checks      = 0;
   int errors      = 0;
   int cyc         = 0;
   int done_seen   = 0;
   int irq_events  = 0;
   int irq_checked = 0;
   int irq_cycle   = 0;
   int wait_states = 0;
   int wcnt        = 0;
   int setup_cyc   = 0;
   logic        err_inject = 1'b0;
   logic        tm_en;
   logic [31:0] tm_cnt;
   logic [9:0]  setup_addr;
   logic [31:0] setup_data;

   apb_wr_t        apb_q[$];
   logic [2*N-1:0] done_q[$];

   always @(posedge pclk) cyc <= cyc + 1;

   // APB slave responder: optional wait states and a slave error on VALUE
   always @(posedge pclk) begin
      #1;
      apb.prdata  = '0;
      apb.pslverr = 1'b0;
      if (apb.psel && !apb.penable) begin
         wcnt       = wait_states;
         apb.pready = 1'b1;
      end else if (apb.psel && apb.penable) begin
         apb.pready = (wcnt == 0);
         if (wcnt > 0) wcnt--;
         apb.pslverr = err_inject && apb.pready && (apb.paddr == 10'h001);
      end else begin
         apb.pready = 1'b1;
      end
   end

   // Behavioural timer: counts VALUE down once enabled, raises timerint
   always @(negedge pclk) begin
      if (!presetn) begin
         tm_en    = 1'b0;
         tm_cnt   = '0;
         timerint = 1'b0;
      end else begin
         if (tm_en && !timerint) begin
            if (tm_cnt <= 1) begin
               timerint = 1'b1;
               if (busy && !apb.psel && (done == '0)) begin
                  irq_cycle = cyc;
                  irq_events++;
               end
            end else begin
               tm_cnt--;
            end
         end
         if (apb.psel && apb.penable && apb.pready) begin
            case (apb.paddr)
               10'h001: tm_cnt = apb.pwdata;
               10'h000: tm_en  = apb.pwdata[0];
               10'h003: if (apb.pwdata[0]) timerint = 1'b0;
               default: ;
            endcase
         end
      end
   end

   // Monitor: compares committed writes and done/err pulses against the queues
   always @(negedge pclk) begin
      apb_wr_t        e;
      logic [2*N-1:0] de;
      if (presetn) begin
         if (apb.psel && !apb.penable) begin
            setup_addr = apb.paddr;
            setup_data = apb.pwdata;
            setup_cyc  = cyc;
         end
         if (apb.psel && apb.penable && apb.pready) begin
            $display("[%0d] APB write addr=0x%03h data=0x%08h", cyc, apb.paddr, apb.pwdata);
            checks++;
            if (apb_q.size() == 0) begin
               errors++;
               $display("FAIL apb_unexpected: got addr=0x%03h data=0x%08h, expected no transfer",
                        apb.paddr, apb.pwdata);
            end else begin
               e = apb_q.pop_front();
               if (apb.paddr !== e.addr || apb.pwdata !== e.data || apb.pwrite !== 1'b1) begin
                  errors++;
                  $display("FAIL apb_write: got addr=0x%03h data=0x%08h pwrite=%b, expected addr=0x%03h data=0x%08h pwrite=1",
                           apb.paddr, apb.pwdata, apb.pwrite, e.addr, e.data);
               end
               checks++;
               if (apb.paddr !== setup_addr || apb.pwdata !== setup_data) begin
                  errors++;
                  $display("FAIL apb_stable: got addr=0x%03h data=0x%08h, expected SETUP values addr=0x%03h data=0x%08h",
                           apb.paddr, apb.pwdata, setup_addr, setup_data);
               end
               checks++;
               if (cyc - setup_cyc + 1 != 2 + wait_states) begin
                  errors++;
                  $display("FAIL apb_length: got %0d cycles, expected %0d", cyc - setup_cyc + 1, 2 + wait_states);
               end
            end
         end
         if (done != '0 || err != '0) begin
            done_seen++;
            $display("[%0d] DONE done=%b err=%b", cyc, done, err);
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: got done=%b err=%b, expected no pulse", done, err);
            end else begin
               de = done_q.pop_front();
               if ({err, done} !== de) begin
                  errors++;
                  $display("FAIL done_err: got done=%b err=%b, expected done=%b err=%b",
                           done, err, de[N-1:0], de[2*N-1:N]);
               end
            end
            if (irq_events != irq_checked) begin
               irq_checked = irq_events;
               checks++;
               if (cyc - irq_cycle != 5) begin
                  errors++;
                  $display("FAIL irq_to_done: got %0d cycles, expected 5", cyc - irq_cycle);
               end
            end
         end
      end
   end

   function automatic apb_wr_t wr(input logic [9:0] a, input logic [31:0] d);
      apb_wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   function automatic logic [N-1:0] onehot(input int c);
      logic [N-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   task automatic push_program(input logic [31:0] d);
      apb_q.push_back(wr(10'h002, 32'h0));
      apb_q.push_back(wr(10'h001, d));
      apb_q.push_back(wr(10'h000, 32'h9));
   endtask

   task automatic push_normal(input int c, input logic [31:0] d);
      push_program(d);
      apb_q.push_back(wr(10'h003, 32'h1));
      apb_q.push_back(wr(10'h000, 32'h0));
      done_q.push_back({{N{1'b0}}, onehot(c)});
   endtask

   task automatic push_slverr(input int c, input logic [31:0] d);
      apb_q.push_back(wr(10'h002, 32'h0));
      apb_q.push_back(wr(10'h001, d));
      apb_q.push_back(wr(10'h003, 32'h1));
      apb_q.push_back(wr(10'h000, 32'h0));
      done_q.push_back({onehot(c), onehot(c)});
   endtask

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_seen < target && n < LIMIT) begin
         @(negedge pclk);
         n++;
      end
      if (done_seen < target) begin
         checks++;
         errors++;
         $display("FAIL wait_done: got %0d done pulses, expected %0d within %0d cycles", done_seen, target, LIMIT);
      end
   endtask

   task automatic wait_irq_state();
      int n = 0;
      while (!(apb_q.size() == 0 && busy && !apb.psel && done == '0) && n < LIMIT) begin
         @(negedge pclk);
         n++;
      end
      if (n >= LIMIT) begin
         checks++;
         errors++;
         $display("FAIL wait_irq_state: got timeout, expected WAIT_IRQ within %0d cycles", LIMIT);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected completion before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      presetn   = 1'b0;
      req       = '0;
      req_delay = '0;
      repeat (3) @(negedge pclk);
      check_eq("reset_busy",  {63'd0, busy}, 64'd0);
      check_eq("reset_done",  {56'd0, err, done}, 64'd0);
      check_eq("reset_apb",   {20'd0, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, 64'd0);
      presetn = 1'b1;
      @(negedge pclk);

      // Round robin: 0,1,3 twice with requests held
      for (int k = 0; k < 2; k++) begin
         push_normal(0, 32'd3);
         push_normal(1, 32'd4);
         push_normal(3, 32'd6);
      end
      req_delay = {32'd6, 32'd0, 32'd4, 32'd3};
      req       = 4'b1011;
      wait_done(6);
      req = '0;
      repeat (2) @(negedge pclk);

      // Single request, delay 5
      push_normal(0, 32'd5);
      req_delay = {32'd0, 32'd0, 32'd0, 32'd5};
      req       = 4'b0001;
      wait_done(7);
      req = '0;
      repeat (2) @(negedge pclk);

      // Three wait states in every ACCESS
      wait_states = 3;
      push_normal(0, 32'd2);
      req_delay = {32'd0, 32'd0, 32'd0, 32'd2};
      req       = 4'b0001;
      wait_done(8);
      req = '0;
      repeat (2) @(negedge pclk);
      wait_states = 0;

      // Slave error on the VALUE write
      err_inject = 1'b1;
      push_slverr(1, 32'd7);
      req_delay = {32'd0, 32'd0, 32'd7, 32'd0};
      req       = 4'b0010;
      wait_done(9);
      req = '0;
      repeat (2) @(negedge pclk);
      err_inject = 1'b0;

      // Zero delay: no APB traffic, done and err together
      done_q.push_back({onehot(2), onehot(2)});
      req_delay = '0;
      req       = 4'b0100;
      wait_done(10);
      req = '0;
      repeat (2) @(negedge pclk);

      // Reset while waiting for the interrupt
      push_program(32'd1000);
      req_delay = {32'd0, 32'd0, 32'd0, 32'd1000};
      req       = 4'b0001;
      wait_irq_state();
      presetn = 1'b0;
      #1;
      check_eq("async_reset_busy",    {63'd0, busy}, 64'd0);
      check_eq("async_reset_psel",    {62'd0, apb.psel, apb.penable}, 64'd0);
      req = '0;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);
      push_normal(0, 32'd3);
      push_normal(1, 32'd4);
      req_delay = {32'd0, 32'd0, 32'd4, 32'd3};
      req       = 4'b0011;
      wait_done(11);
      req = 4'b0010;
      wait_done(12);
      req = '0;

      repeat (10) @(negedge pclk);
      check_eq("apb_queue_empty",  64'(apb_q.size()), 64'd0);
      check_eq("done_queue_empty", 64'(done_q.size()), 64'd0);
      check_eq("done_total",       64'(done_seen), 64'd12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
